dip_debounce: RTL

- Input-conditioning stage that sits directly upstream of the two-input logic-gate block. It takes raw, asynchronous, bouncing DIP switch levels and produces clean, synchronous levels for the gate inputs. It also produces one-cycle edge pulses for later counter/FSM labs.
- Each channel is independent: a 2-flop synchronizer followed by a per-channel debounce FSM and counter.

---
 rtl/dip_debounce.sv | 99 +++++++++
 1 files changed

// File: rtl/dip_debounce.sv
// dip_debounce: conditions raw, bouncing DIP switch levels into clean synchronous
// levels. Each channel is a 2-flop synchronizer feeding a STABLE/WAIT debounce FSM
// with a qualification counter. The FSM emits a registered one-cycle rise or fall
// pulse when it accepts a new level.
module dip_debounce #(
    parameter int CH              = 2,
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_W           = 16
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic [CH-1:0] DIP_IN,
    output logic [CH-1:0] DIP_OUT,
    output logic [CH-1:0] DIP_RISE,
    output logic [CH-1:0] DIP_FALL,
    output logic          BUSY
);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_WAIT   = 1'b1
    } state_e;

    // Count value at which the final stable sample commits the new level.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CH-1:0] sync1_q;
    logic [CH-1:0] sync2_q;
    logic [CH-1:0] busy_vec;

    // Two-flop synchronizer: the only place DIP_IN is sampled.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: clocked state uses non-blocking (<=) so every flop samples pre-edge values.
        if (!RST_N) begin
            sync1_q <= '0;
            sync2_q <= '0;
        end else begin
            sync1_q <= DIP_IN;
            sync2_q <= sync1_q;
        end
    end

    for (genvar i = 0; i < CH; i++) begin : g_ch
        state_e           state_q;
        logic [CNT_W-1:0] cnt_q;
        logic             out_q;
        logic             rise_q;
        logic             fall_q;

        // Per-channel debounce FSM: qualify a change for DEBOUNCE_CYCLES samples, then commit.
        always_ff @(posedge CLK or negedge RST_N) begin
            if (!RST_N) begin
                state_q <= ST_STABLE;
                cnt_q   <= '0;
                out_q   <= 1'b0;
                rise_q  <= 1'b0;
                fall_q  <= 1'b0;
            end else begin
                // Pulses are high for one cycle only; the commit branch overrides these.
                rise_q <= 1'b0;
                fall_q <= 1'b0;
                unique case (state_q)
                    ST_STABLE: begin
                        if (sync2_q[i] != out_q) begin
                            state_q <= ST_WAIT;
                            cnt_q   <= CNT_W'(1);
                        end else begin
                            cnt_q   <= '0;
                        end
                    end
                    ST_WAIT: begin
                        if (sync2_q[i] == out_q) begin
                            // Input returned to the accepted level: treat as a bounce.
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else if (cnt_q == CNT_LAST) begin
                            out_q   <= sync2_q[i];
                            rise_q  <= sync2_q[i];
                            fall_q  <= ~sync2_q[i];
                            state_q <= ST_STABLE;
                            cnt_q   <= '0;
                        end else begin
                            cnt_q   <= cnt_q + CNT_W'(1);
                        end
                    end
                endcase
            end
        end

        assign DIP_OUT[i]  = out_q;
        assign DIP_RISE[i] = rise_q;
        assign DIP_FALL[i] = fall_q;
        assign busy_vec[i] = (state_q == ST_WAIT);
    end

    // BUSY depends on FSM state registers only, never on DIP_IN.
    assign BUSY = |busy_vec;

endmodule
